input_delay_lanes: RTL and testbench

INPUT_DELAY_LANES -- requirements
Module: input_delay_lanes

---
 rtl/input_delay_lanes.sv | 223 ++++++++++++++++++++++
 tb/tb_input_delay_lanes.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_delay_lanes.sv
// Per-lane input delay tuning.
//
// Each data bit passes through its own delay_unit. All WIDTH bits of a lane share one
// thermometer-coded tap select. A small command FSM steps one lane's tap up or down,
// or zeroes every lane. After each command the FSM waits for the delay line to settle
// and then pulses ack.
//
// Ports:
//   clk, rst                    clock; asynchronous active-high reset
//   data_in / data_out          LANES*WIDTH bits; lane n occupies [n*WIDTH +: WIDTH]
//   idelay_rst                  command: zero all lane taps (wins over idelay_ce)
//   idelay_ce                   command: step the tap of idelay_lane
//   idelay_inc                  step direction (1 = increment, 0 = decrement)
//   idelay_lane                 lane targeted by a step
//   busy                        a command is in progress
//   ack                         one-cycle completion pulse
//   sat, err, tap_out           result of the last command; updated with ack

module delay_unit #(
  parameter int unsigned TAPS = 4
) (
  input  logic            din,
  input  logic [TAPS-1:0] sel,
  output logic            dout
);

  // Each stage stands for one technology delay element. Behaviourally it is a buffer,
  // so every tap carries the same logic value. A thermometer sel picks the deepest
  // enabled stage.
  logic [TAPS:0] stage;

  always_comb begin
    stage    = '0;
    stage[0] = din;
    for (int k = 0; k < TAPS; k++) begin
      stage[k+1] = stage[k];
    end
    dout = stage[0];
    for (int k = 0; k < TAPS; k++) begin
      if (sel[k]) begin
        dout = stage[k+1];
      end
    end
  end

endmodule

module input_delay_lanes #(
  parameter int unsigned LANES     = 2,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned TAPS      = 4,
  parameter int unsigned SETTLE    = 4,
  parameter int unsigned LANE_BITS = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LANES*WIDTH-1:0]       data_in,
  output logic [LANES*WIDTH-1:0]       data_out,
  input  logic                         idelay_rst,
  input  logic                         idelay_ce,
  input  logic                         idelay_inc,
  input  logic [LANE_BITS-1:0]         idelay_lane,
  output logic                         busy,
  output logic                         ack,
  output logic                         sat,
  output logic                         err,
  output logic [$clog2(TAPS+1)-1:0]    tap_out
);

  localparam int unsigned TW = $clog2(TAPS + 1);
  localparam int unsigned CW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {StIdle, StApply, StWait} state_e;

  state_e                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         cmd_rst_q, cmd_rst_d;
  logic                         cmd_inc_q, cmd_inc_d;
  logic [LANE_BITS-1:0]         cmd_lane_q, cmd_lane_d;
  logic [LANES-1:0][TW-1:0]     tap_q, tap_d;
  logic [LANES-1:0][TAPS-1:0]   sel_q, sel_d;
  // Result computed in APPLY, published on ack.
  logic                         res_sat_q, res_sat_d;
  logic                         res_err_q, res_err_d;
  logic [TW-1:0]                res_tap_q, res_tap_d;
  logic                         ack_q, ack_d;
  logic                         sat_q, sat_d;
  logic                         err_q, err_d;
  logic [TW-1:0]                tap_out_q, tap_out_d;
  logic                         lane_hit;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_rst_d  = cmd_rst_q;
    cmd_inc_d  = cmd_inc_q;
    cmd_lane_d = cmd_lane_q;
    tap_d      = tap_q;
    res_sat_d  = res_sat_q;
    res_err_d  = res_err_q;
    res_tap_d  = res_tap_q;
    ack_d      = 1'b0;
    sat_d      = sat_q;
    err_d      = err_q;
    tap_out_d  = tap_out_q;
    lane_hit   = 1'b0;

    // The sel registers trail the tap counters by one cycle.
    for (int l = 0; l < LANES; l++) begin
      for (int k = 0; k < TAPS; k++) begin
        sel_d[l][k] = (tap_q[l] > TW'(k));
      end
    end

    unique case (state_q)
      StIdle: begin
        if (idelay_rst || idelay_ce) begin
          cmd_rst_d  = idelay_rst;
          cmd_inc_d  = idelay_inc;
          cmd_lane_d = idelay_lane;
          state_d    = StApply;
        end
      end
      StApply: begin
        state_d = StWait;
        cnt_d   = '0;
        if (cmd_rst_q) begin
          tap_d     = '0;
          res_sat_d = 1'b0;
          res_err_d = 1'b0;
          res_tap_d = '0;
        end else begin
          res_sat_d = 1'b0;
          res_err_d = 1'b0;
          for (int l = 0; l < LANES; l++) begin
            if (cmd_lane_q == LANE_BITS'(l)) begin
              lane_hit = 1'b1;
              if (cmd_inc_q) begin
                if (tap_q[l] < TW'(TAPS)) tap_d[l] = tap_q[l] + TW'(1);
                else                      res_sat_d = 1'b1;
              end else begin
                if (tap_q[l] != '0) tap_d[l] = tap_q[l] - TW'(1);
                else                res_sat_d = 1'b1;
              end
              res_tap_d = tap_d[l];
            end
          end
          // A lane index beyond LANES touches nothing and keeps the reported tap.
          if (!lane_hit) begin
            res_err_d = 1'b1;
            res_sat_d = 1'b0;
            res_tap_d = tap_out_q;
          end
        end
      end
      StWait: begin
        if (cnt_q == CW'(SETTLE)) begin
          state_d   = StIdle;
          ack_d     = 1'b1;
          sat_d     = res_sat_q;
          err_d     = res_err_q;
          tap_out_d = res_tap_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      cmd_rst_q  <= 1'b0;
      cmd_inc_q  <= 1'b0;
      cmd_lane_q <= '0;
      tap_q      <= '0;
      sel_q      <= '0;
      res_sat_q  <= 1'b0;
      res_err_q  <= 1'b0;
      res_tap_q  <= '0;
      ack_q      <= 1'b0;
      sat_q      <= 1'b0;
      err_q      <= 1'b0;
      tap_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_rst_q  <= cmd_rst_d;
      cmd_inc_q  <= cmd_inc_d;
      cmd_lane_q <= cmd_lane_d;
      tap_q      <= tap_d;
      sel_q      <= sel_d;
      res_sat_q  <= res_sat_d;
      res_err_q  <= res_err_d;
      res_tap_q  <= res_tap_d;
      ack_q      <= ack_d;
      sat_q      <= sat_d;
      err_q      <= err_d;
      tap_out_q  <= tap_out_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign ack     = ack_q;
  assign sat     = sat_q;
  assign err     = err_q;
  assign tap_out = tap_out_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      delay_unit #(
        .TAPS (TAPS)
      ) u_delay (
        .din  (data_in[l*WIDTH+b]),
        .sel  (sel_q[l]),
        .dout (data_out[l*WIDTH+b])
      );
    end
  end

endmodule

// File: tb/tb_input_delay_lanes.sv
module tb_input_delay_lanes;

  localparam int TAPS   = 4;
  localparam int SETTLE = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: LANES=2, WIDTH=8, LANE_BITS=1
  logic        rst2, irst2, ce2, inc2, busy2, ack2, sat2, err2;
  logic [0:0]  lane2;
  logic [15:0] din2, dout2;
  logic [2:0]  tout2;
  // DUT B: LANES=3, WIDTH=4, LANE_BITS=2
  logic        rst3, irst3, ce3, inc3, busy3, ack3, sat3, err3;
  logic [1:0]  lane3;
  logic [11:0] din3, dout3;
  logic [2:0]  tout3;

  input_delay_lanes #(
    .LANES(2), .WIDTH(8), .TAPS(TAPS), .SETTLE(SETTLE), .LANE_BITS(1)
  ) u2 (
    .clk(clk), .rst(rst2), .data_in(din2), .data_out(dout2), .idelay_rst(irst2),
    .idelay_ce(ce2), .idelay_inc(inc2), .idelay_lane(lane2), .busy(busy2), .ack(ack2),
    .sat(sat2), .err(err2), .tap_out(tout2)
  );

  input_delay_lanes #(
    .LANES(3), .WIDTH(4), .TAPS(TAPS), .SETTLE(SETTLE), .LANE_BITS(2)
  ) u3 (
    .clk(clk), .rst(rst3), .data_in(din3), .data_out(dout3), .idelay_rst(irst3),
    .idelay_ce(ce3), .idelay_inc(inc3), .idelay_lane(lane3), .busy(busy3), .ack(ack3),
    .sat(sat3), .err(err3), .tap_out(tout3)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: per-DUT lane taps and last reported result.
  int mtap [2][3];
  int mtout [2];
  int msat [2];
  int merr [2];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int therm(input int t);
    int r = 0;
    for (int k = 0; k < TAPS; k++) if (t > k) r = r | (1 << k);
    return r;
  endfunction

  task automatic model_step(input int w, input bit rc, input bit inc, input int lane);
    int nl = (w == 0) ? 2 : 3;
    if (rc) begin
      for (int l = 0; l < 3; l++) mtap[w][l] = 0;
      mtout[w] = 0; msat[w] = 0; merr[w] = 0;
    end else if (lane >= nl) begin
      merr[w] = 1; msat[w] = 0;
    end else begin
      merr[w] = 0;
      msat[w] = 0;
      if (inc) begin
        if (mtap[w][lane] < TAPS) mtap[w][lane]++;
        else msat[w] = 1;
      end else begin
        if (mtap[w][lane] > 0) mtap[w][lane]--;
        else msat[w] = 1;
      end
      mtout[w] = mtap[w][lane];
    end
  endtask

  task automatic model_reset(input int w);
    for (int l = 0; l < 3; l++) mtap[w][l] = 0;
    mtout[w] = 0; msat[w] = 0; merr[w] = 0;
  endtask

  task automatic check_state(input int w, input string tag);
    if (w == 0) begin
      check({tag, "_sat"}, sat2, msat[0]);
      check({tag, "_err"}, err2, merr[0]);
      check({tag, "_tap_out"}, tout2, mtout[0]);
      for (int l = 0; l < 2; l++) check({tag, "_sel"}, u2.sel_q[l], therm(mtap[0][l]));
      check({tag, "_data"}, dout2, din2);
    end else begin
      check({tag, "_sat"}, sat3, msat[1]);
      check({tag, "_err"}, err3, merr[1]);
      check({tag, "_tap_out"}, tout3, mtout[1]);
      for (int l = 0; l < 3; l++) check({tag, "_sel"}, u3.sel_q[l], therm(mtap[1][l]));
      check({tag, "_data"}, dout3, din3);
    end
  endtask

  // Issue one command, measure ack latency, then compare against the model in the
  // ack cycle. Index 1 is the cycle right after the sampling edge.
  task automatic do_cmd(input int w, input bit rc, input bit inc, input int lane,
                        input string tag);
    int got = 0;
    @(negedge clk);
    if (w == 0) begin
      irst2 = rc; ce2 = 1'b1; inc2 = inc; lane2 = 1'(lane); din2 = 16'($urandom);
    end else begin
      irst3 = rc; ce3 = 1'b1; inc3 = inc; lane3 = 2'(lane); din3 = 12'($urandom);
    end
    @(negedge clk);
    irst2 = 1'b0; ce2 = 1'b0; irst3 = 1'b0; ce3 = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if ((w == 0) ? ack2 : ack3) begin
        got = n;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_latency"}, got, SETTLE + 3);
    model_step(w, rc, inc, lane);
    check_state(w, tag);
  endtask

  typedef struct {
    bit rc;
    bit inc;
    int lane;
    int exp_tap;
    bit exp_sat;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    rst2 = 1'b1; irst2 = 0; ce2 = 0; inc2 = 0; lane2 = 0; din2 = 16'h5a3c;
    rst3 = 1'b1; irst3 = 0; ce3 = 0; inc3 = 0; lane3 = 0; din3 = 12'h9c1;
    model_reset(0);
    model_reset(1);
    repeat (2) @(negedge clk);
    check("reset_busy2", busy2, 0);
    check("reset_ack2", ack2, 0);
    check("reset_busy3", busy3, 0);
    check_state(0, "reset2");
    check_state(1, "reset3");
    rst2 = 1'b0; rst3 = 1'b0;

    // Inc lane 1 up to and past the bound, dec lane 0 at zero, then a combined
    // idelay_rst+idelay_ce with lane 1 at tap 3.
    vecs[0]  = '{0, 1, 1, 1, 0};
    vecs[1]  = '{0, 1, 1, 2, 0};
    vecs[2]  = '{0, 1, 1, 3, 0};
    vecs[3]  = '{0, 1, 1, 4, 0};
    vecs[4]  = '{0, 1, 1, 4, 1};
    vecs[5]  = '{0, 0, 0, 0, 1};
    vecs[6]  = '{0, 0, 1, 3, 0};
    vecs[7]  = '{1, 1, 1, 0, 0};
    vecs[8]  = '{0, 1, 0, 1, 0};
    vecs[9]  = '{0, 0, 0, 0, 0};
    vecs[10] = '{0, 0, 0, 0, 1};
    vecs[11] = '{0, 1, 0, 1, 0};
    for (int i = 0; i < 12; i++) begin
      do_cmd(0, vecs[i].rc, vecs[i].inc, vecs[i].lane, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_tab_tap", i), tout2, vecs[i].exp_tap);
      check($sformatf("vec%0d_tab_sat", i), sat2, vecs[i].exp_sat);
      if (i == 4) begin
        check("vec4_sel1_full", u2.sel_q[1], 4'b1111);
        check("vec4_sel0_zero", u2.sel_q[0], 4'b0000);
      end
    end

    // Out-of-range lane on the 3-lane instance.
    do_cmd(1, 0, 1, 2, "l3_inc2");
    do_cmd(1, 0, 1, 3, "l3_bad");
    check("l3_bad_err", err3, 1);
    check("l3_bad_tap_out", tout3, 1);
    do_cmd(1, 0, 1, 0, "l3_inc0");
    check("l3_inc0_err", err3, 0);

    // ce held for 12 cycles: busy commands are dropped.
    @(negedge clk);
    ce2 = 1'b1; inc2 = 1'b1; lane2 = 1'b0;
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ack2) acks++;
      check("burst_busy", busy2, !ack2);
    end
    ce2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack2) acks++;
    end
    check("burst_acks", acks, 2);
    model_step(0, 0, 1, 0);
    model_step(0, 0, 1, 0);
    check_state(0, "burst");

    // Random commands against the model.
    for (int i = 0; i < 30; i++) begin
      do_cmd(0, ($urandom_range(0, 9) == 0), 1'($urandom), int'($urandom_range(0, 1)),
             $sformatf("rnd%0d", i));
    end
    for (int i = 0; i < 10; i++) begin
      do_cmd(1, ($urandom_range(0, 9) == 0), 1'($urandom), int'($urandom_range(0, 3)),
             $sformatf("rnd3_%0d", i));
    end

    // Reset asserted in WAIT between clock edges.
    do_cmd(0, 0, 1, 1, "pre_abort");
    @(negedge clk);
    ce2 = 1'b1; inc2 = 1'b1; lane2 = 1'b1;
    @(negedge clk);
    ce2 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst2 = 1'b1;
    #1;
    model_reset(0);
    check("abort_busy", busy2, 0);
    check("abort_ack", ack2, 0);
    check("abort_sel0", u2.sel_q[0], 0);
    check("abort_sel1", u2.sel_q[1], 0);
    check("abort_tap_out", tout2, 0);
    acks = 0;
    repeat (2) @(negedge clk);
    rst2 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ack2) acks++;
    end
    check("abort_no_ack", acks, 0);
    do_cmd(0, 0, 1, 0, "post_abort");
    check("post_abort_tap1", tout2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
